// File: rtl/out_pin_pkg.sv
// Shared encodings and default constants for the multi-channel output pin block.
package out_pin_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_TOGGLE = 2'd1,
    MODE_PULSE  = 2'd2,
    MODE_BURST  = 2'd3
  } mode_t;

  localparam int          DEF_CNT_W        = 24;
  localparam logic [23:0] DEF_RESET_PERIOD = 24'd8000000;
  localparam int          DEF_BURST_LEN    = 8;

endpackage

// File: rtl/out_pin_chan.sv
// One output channel: period counter, mode/period registers, burst counter,
// registered pin and sticky burst-done flag. A load strobe replaces the
// configuration and restarts the channel from a cleared state.
module out_pin_chan
  import out_pin_pkg::*;
#(
  parameter int                CNT_W        = DEF_CNT_W,
  parameter mode_t             RESET_MODE   = MODE_TOGGLE,
  parameter logic [CNT_W-1:0]  RESET_PERIOD = CNT_W'(DEF_RESET_PERIOD),
  parameter int                BURST_LEN    = DEF_BURST_LEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  mode_t            load_mode,
  input  logic [CNT_W-1:0] load_period,
  output logic             pin,
  output logic             done
);

  localparam logic [7:0] BURST_END = 8'(BURST_LEN);

  mode_t            mode;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last;
  logic [CNT_W-1:0] cnt_next;
  logic [7:0]       bcnt;
  logic             evt;

  // A programmed period of 0 behaves as 1, so the terminal count is 0 in both cases.
  assign last     = (period == '0) ? '0 : period - CNT_W'(1);
  assign evt      = (cnt == last);
  assign cnt_next = evt ? '0 : cnt + CNT_W'(1);

  // Counter and output update; load takes priority over the running mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode   <= RESET_MODE;
      period <= RESET_PERIOD;
      cnt    <= '0;
      bcnt   <= '0;
      pin    <= 1'b0;
      done   <= 1'b0;
    end else if (load) begin
      mode   <= load_mode;
      period <= load_period;
      cnt    <= '0;
      bcnt   <= '0;
      pin    <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (mode)
        MODE_TOGGLE: begin
          cnt <= cnt_next;
          if (evt) pin <= ~pin;
        end
        MODE_PULSE: begin
          cnt <= cnt_next;
          pin <= evt;
        end
        MODE_BURST: begin
          // Once the last pulse has been shown, freeze the counter and latch done.
          if (bcnt == BURST_END) begin
            pin  <= 1'b0;
            done <= 1'b1;
          end else begin
            cnt <= cnt_next;
            pin <= evt;
            if (evt) bcnt <= bcnt + 8'd1;
          end
        end
        default: begin
          cnt <= '0;
          pin <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/out_pin_multi.sv
// Multi-channel output pin driver: NUM_CH independent toggle/pulse/burst
// channels reprogrammed one at a time through a valid/ready config port.
// Build option OUT_PIN_HEARTBEAT_EN adds a free-running heartbeat counter;
// LED then shows the heartbeat bit OR any burst-done flag, otherwise LED
// follows PIN[0]. USBPU is tied low.
module out_pin_multi
  import out_pin_pkg::*;
#(
  parameter int               NUM_CH       = 2,
  parameter int               CNT_W        = DEF_CNT_W,
  parameter logic [1:0]       RESET_MODE   = 2'd1,
  parameter logic [CNT_W-1:0] RESET_PERIOD = CNT_W'(DEF_RESET_PERIOD),
  parameter int               BURST_LEN    = DEF_BURST_LEN,
`ifdef OUT_PIN_HEARTBEAT_EN
  parameter int               HB_BIT       = 22,
`endif
  localparam int              CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [CNT_W-1:0]  cfg_period,
  output logic [NUM_CH-1:0] PIN,
  output logic [NUM_CH-1:0] done,
  output logic              LED,
  output logic              USBPU
);

  logic              xfer;
  logic [NUM_CH-1:0] load;

  assign xfer = cfg_valid & cfg_ready;

  // Ready drops for exactly one cycle after every accepted transfer.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cfg_ready <= 1'b1;
    else        cfg_ready <= ~xfer;
  end

  // Channel numbers at or above NUM_CH match no load strobe, so the transfer is absorbed.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign load[g] = xfer && (cfg_ch == CH_W'(g));

    out_pin_chan #(
      .CNT_W       (CNT_W),
      .RESET_MODE  (mode_t'(RESET_MODE)),
      .RESET_PERIOD(RESET_PERIOD),
      .BURST_LEN   (BURST_LEN)
    ) u_chan (
      .clk        (CLK),
      .rst_n      (RST_N),
      .load       (load[g]),
      .load_mode  (mode_t'(cfg_mode)),
      .load_period(cfg_period),
      .pin        (PIN[g]),
      .done       (done[g])
    );
  end

`ifdef OUT_PIN_HEARTBEAT_EN
  logic [HB_BIT:0] hb_cnt;

  // Free-running heartbeat counter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) hb_cnt <= '0;
    else        hb_cnt <= hb_cnt + 1'b1;
  end

  assign LED = hb_cnt[HB_BIT] | (|done);
`else
  assign LED = PIN[0];
`endif

  assign USBPU = 1'b0;

endmodule
